// File: rtl/codix_risc_dbg_responder.sv
// ---------------------------------------------------------------------------
// codix_risc_dbg_responder
//
// Backdoor-access responder for the codix_risc platform. It takes single
// read/write commands aimed at data memory or the general register file and
// executes each one on the memory bus or the register-file debug port. It
// returns exactly one response per accepted command. Only one command is in
// flight at a time.
//
// Ports
//   CLK, RST                clock (rising edge), synchronous active-high reset
//   req_valid/req_ready     command handshake
//   req_write, req_target   1 = write / 0 = read; 0 = memory / 1 = register
//   req_addr, req_wdata     byte address or register index, write data
//   rsp_valid/rsp_ready     response handshake
//   rsp_rdata, rsp_err      read data (0 for writes/errors), error code
//   core_halt               core halt status, sampled at acceptance
//   mem_req/mem_we/mem_addr/mem_wdata/mem_ack/mem_rdata
//                           memory bus, request held until ack or timeout
//   rf_re/rf_we/rf_addr/rf_wdata/rf_rdata
//                           register-file debug port, one-cycle strobes,
//                           read data returned the cycle after rf_re
// ---------------------------------------------------------------------------
module codix_risc_dbg_responder #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RST,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_target,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_err,

    input  logic              core_halt,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              rf_re,
    output logic              rf_we,
    output logic [4:0]        rf_addr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] rf_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        MEM_WAIT,
        RF_ACC,
        RF_CAP,
        RESP
    } state_t;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_RUNNING = 2'd1;
    localparam logic [1:0] ERR_ADDR    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    // The wait counter counts MEM_WAIT cycles already spent without an ack;
    // the last permitted cycle is the one where it equals TIMEOUT-1.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_t              state, state_d;
    logic                wr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [15:0]         wait_cnt;

    logic                accept;
    logic [1:0]          acc_err;
    logic                mem_last;

    // ------------------------------------------------------------------
    // Acceptance checks. core_halt is evaluated here and only here, so a
    // halt change after acceptance cannot affect the command in flight.
    // ------------------------------------------------------------------
    // NOTE: every signal written in an always_comb gets a default on the
    // first line, so no path through the block can infer a latch.
    always_comb begin
        acc_err = ERR_OK;
        if (!core_halt) begin
            acc_err = ERR_RUNNING;
        end else if (!req_target && (req_addr[1:0] != 2'b00)) begin
            acc_err = ERR_ADDR;
        end else if (req_target && (|req_addr[ADDR_W-1:5])) begin
            acc_err = ERR_ADDR;
        end
    end

    // req_ready is gated by RST so the block never advertises readiness
    // while reset is applied, and rises in the first cycle after release.
    assign req_ready = (state == IDLE) && !RST;
    assign accept    = req_valid && req_ready;
    assign mem_last  = (wait_cnt == WAIT_LAST);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (acc_err != ERR_OK) begin
                        state_d = RESP;
                    end else if (req_target) begin
                        state_d = RF_ACC;
                    end else begin
                        state_d = MEM_WAIT;
                    end
                end
            end
            MEM_WAIT: begin
                // An ack in the last permitted cycle still counts as success.
                if (mem_ack || mem_last) begin
                    state_d = RESP;
                end
            end
            RF_ACC: begin
                state_d = wr_q ? RESP : RF_CAP;
            end
            RF_CAP: begin
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Command and response registers
    // ------------------------------------------------------------------
    // NOTE: every datapath register is reset because its value is visible
    // on an output port and must read 0 straight out of reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wait_cnt  <= '0;
            rsp_rdata <= '0;
            rsp_err   <= ERR_OK;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        wr_q      <= req_write;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        wait_cnt  <= '0;
                        rsp_rdata <= '0;
                        rsp_err   <= acc_err;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ack) begin
                        rsp_rdata <= wr_q ? '0 : mem_rdata;
                        rsp_err   <= ERR_OK;
                    end else if (mem_last) begin
                        rsp_rdata <= '0;
                        rsp_err   <= ERR_TIMEOUT;
                    end else begin
                        wait_cnt  <= wait_cnt + 16'd1;
                    end
                end
                RF_CAP: begin
                    // Index 0 is passed through as read; the register file
                    // owns the hard-wired-zero behaviour.
                    rsp_rdata <= rf_rdata;
                    rsp_err   <= ERR_OK;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Bus outputs, decoded from state and the latched command. Because
    // they depend only on registers, a reset edge clears them at once.
    // ------------------------------------------------------------------
    assign rsp_valid = (state == RESP);

    assign mem_req   = (state == MEM_WAIT);
    assign mem_we    = mem_req && wr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign rf_re     = (state == RF_ACC) && !wr_q;
    assign rf_we     = (state == RF_ACC) && wr_q;
    assign rf_addr   = addr_q[4:0];
    assign rf_wdata  = wdata_q;

endmodule

// File: tb/tb_codix_risc_dbg_responder.sv
// ---------------------------------------------------------------------------
// tb_codix_risc_dbg_responder
//
// Self-checking bench for codix_risc_dbg_responder (TIMEOUT = 4). The bench
// plays memory and register file from behavioural arrays, predicts each
// response from the command rules (error priority, latency, data) and
// compares what the responder produced.
// ---------------------------------------------------------------------------
module tb_codix_risc_dbg_responder;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;

    logic          CLK, RST;
    logic          req_valid, req_ready, req_write, req_target;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_err;
    logic          core_halt;
    logic          mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          rf_re, rf_we;
    logic [4:0]    rf_addr;
    logic [DW-1:0] rf_wdata, rf_rdata;

    int n_asserts = 0;
    int n_fail    = 0;

    codix_risc_dbg_responder #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_target(req_target), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .core_halt(core_halt),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .rf_re(rf_re), .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
        .rf_rdata(rf_rdata)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Environment models
    logic [DW-1:0] mem_model [logic [31:0]];
    logic [DW-1:0] rf_model  [32];
    bit            late_ack_en = 1'b0;

    function automatic logic [DW-1:0] mem_read(input logic [31:0] a);
        return mem_model.exists(a) ? mem_model[a] : (32'hA5A5_0000 ^ a);
    endfunction

    typedef struct {
        int            lat;       // first rsp_valid cycle, 0 = never
        logic [DW-1:0] rdata;
        logic [1:0]    err;
        int            mem_cyc;   // cycles with mem_req high
        int            rf_re_n;
        int            rf_we_n;
        int            rf_first;  // cycle of first rf strobe
        bit            stable;    // rsp held steady and req_ready low while busy
        bit            mem_ok;    // mem_addr/we/wdata correct while mem_req
        bit            idle_after;
    } obs_t;

    // Expected outcome from the command rules alone.
    function automatic obs_t predict(input bit wr, input bit tgt,
                                     input logic [31:0] addr, input bit halt,
                                     input int ack_delay);
        obs_t e;
        e.lat = 1; e.rdata = '0; e.err = 2'd0; e.mem_cyc = 0;
        e.rf_re_n = 0; e.rf_we_n = 0; e.rf_first = 0;
        e.stable = 1'b1; e.mem_ok = 1'b1; e.idle_after = 1'b1;
        if (!halt) begin
            e.err = 2'd1;
        end else if (!tgt && (addr % 4) != 0) begin
            e.err = 2'd2;
        end else if (tgt && addr >= 32) begin
            e.err = 2'd2;
        end else if (tgt) begin
            e.lat      = wr ? 2 : 3;
            e.rf_we_n  = wr ? 1 : 0;
            e.rf_re_n  = wr ? 0 : 1;
            e.rf_first = 1;
            e.rdata    = wr ? '0 : rf_model[addr];
        end else if (ack_delay >= 1 && ack_delay <= TMO) begin
            e.lat     = ack_delay + 1;
            e.mem_cyc = ack_delay;
            e.rdata   = wr ? '0 : mem_read(addr);
        end else begin
            e.err     = 2'd3;
            e.lat     = TMO + 1;
            e.mem_cyc = TMO;
        end
        return e;
    endfunction

    // Issue one command, play memory/register file, collect observations.
    // Starts and ends at posedge+1. ack_delay 0 = memory never acks.
    // hold = cycles rsp_ready stays low after rsp_valid first appears.
    task automatic run_cmd(input bit wr, input bit tgt, input logic [31:0] addr,
                           input logic [31:0] wd, input bit halt,
                           input int ack_delay, input int hold, output obs_t o);
        int      resp_n;
        bit      done;
        bit      rf_pend;
        logic [4:0] rf_idx;
        o.lat = 0; o.rdata = '0; o.err = 2'd0; o.mem_cyc = 0;
        o.rf_re_n = 0; o.rf_we_n = 0; o.rf_first = 0;
        o.stable = 1'b1; o.mem_ok = 1'b1; o.idle_after = 1'b0;
        for (int w = 0; w < 50 && !req_ready; w++) begin
            @(posedge CLK); #1;
        end
        core_halt  = halt;
        req_valid  = 1'b1;
        req_write  = wr;
        req_target = tgt;
        req_addr   = addr;
        req_wdata  = wd;
        rsp_ready  = 1'b0;
        mem_ack    = 1'b0;
        @(posedge CLK); #1;
        req_valid  = 1'b0;
        req_write  = 1'($urandom);
        req_target = 1'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        core_halt  = 1'($urandom);
        rf_pend = 1'b0;
        rf_idx  = '0;
        resp_n  = 0;
        done    = 1'b0;
        for (int cyc = 1; cyc <= 64 && !done; cyc++) begin
            if (cyc > 1) begin
                @(posedge CLK); #1;
            end
            rf_rdata = rf_pend ? rf_model[rf_idx] : $urandom;
            rf_pend  = 1'b0;
            if (rf_re) begin
                o.rf_re_n++;
                if (o.rf_first == 0) o.rf_first = cyc;
                rf_pend = 1'b1;
                rf_idx  = rf_addr;
            end
            if (rf_we) begin
                o.rf_we_n++;
                if (o.rf_first == 0) o.rf_first = cyc;
                if (rf_addr != 5'd0) rf_model[rf_addr] = rf_wdata;
            end
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            if (mem_req) begin
                o.mem_cyc++;
                if (mem_addr !== addr || mem_we !== wr || mem_wdata !== wd)
                    o.mem_ok = 1'b0;
                if (o.mem_cyc == ack_delay) begin
                    mem_ack = 1'b1;
                    if (wr) mem_model[addr] = wd;
                    else    mem_rdata = mem_read(addr);
                end
            end
            if (req_ready !== 1'b0) o.stable = 1'b0;
            if (rsp_valid) begin
                if (resp_n == 0) begin
                    o.lat   = cyc;
                    o.rdata = rsp_rdata;
                    o.err   = rsp_err;
                end else if (rsp_rdata !== o.rdata || rsp_err !== o.err) begin
                    o.stable = 1'b0;
                end
                if (late_ack_en) mem_ack = 1'b1;
                resp_n++;
                if (resp_n > hold) begin
                    rsp_ready = 1'b1;
                    done      = 1'b1;
                end
            end
        end
        @(posedge CLK); #1;
        rsp_ready = 1'b0;
        mem_ack   = 1'b0;
        core_halt = 1'b1;
        o.idle_after = (req_ready === 1'b1) && (rsp_valid === 1'b0);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        n_asserts++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
        n_asserts++; if ({rsp_valid, mem_req, mem_we, rf_re, rf_we} !== 5'b0) begin n_fail++; $display("FAIL reset_strobes: got %b want 00000", {rsp_valid, mem_req, mem_we, rf_re, rf_we}); end
        n_asserts++; if ({rsp_rdata, rsp_err, mem_addr, mem_wdata, rf_addr, rf_wdata} !== '0) begin n_fail++; $display("FAIL reset_data: rdata=%h err=%0d maddr=%h mwdata=%h raddr=%0d rwdata=%h want all 0", rsp_rdata, rsp_err, mem_addr, mem_wdata, rf_addr, rf_wdata); end
        RST = 1'b0;
        #1;
        n_asserts++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", req_ready); end
        @(posedge CLK); #1;
    endtask

    task automatic test_mem();
        obs_t o;
        run_cmd(1'b1, 1'b0, 32'h100, 32'hDEAD_BEEF, 1'b1, 3, 0, o);
        n_asserts++; if (o.err !== 2'd0 || o.rdata !== '0) begin n_fail++; $display("FAIL mem_wr_rsp: err=%0d rdata=%h want err=0 rdata=0", o.err, o.rdata); end
        n_asserts++; if (o.mem_cyc != 3 || o.lat != 4) begin n_fail++; $display("FAIL mem_wr_timing: mem_req cycles=%0d lat=%0d want 3 and 4", o.mem_cyc, o.lat); end
        n_asserts++; if (!o.mem_ok) begin n_fail++; $display("FAIL mem_wr_bus: addr/we/wdata not held at 0x100/1/DEADBEEF"); end
        run_cmd(1'b0, 1'b0, 32'h100, 32'h0, 1'b1, 3, 0, o);
        n_asserts++; if (o.err !== 2'd0 || o.rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL mem_rd_rsp: err=%0d rdata=%h want err=0 rdata=deadbeef", o.err, o.rdata); end
        n_asserts++; if (o.mem_cyc != 3 || o.lat != 4 || !o.mem_ok) begin n_fail++; $display("FAIL mem_rd_timing: mem_req cycles=%0d lat=%0d bus_ok=%b want 3, 4, 1", o.mem_cyc, o.lat, o.mem_ok); end
    endtask

    task automatic test_regs();
        obs_t o;
        run_cmd(1'b1, 1'b1, 32'd5, 32'h1234_5678, 1'b1, 0, 0, o);
        n_asserts++; if (o.rf_we_n != 1 || o.rf_re_n != 0 || o.rf_first != 1) begin n_fail++; $display("FAIL rf_wr_strobe: we=%0d re=%0d first=%0d want 1,0,1", o.rf_we_n, o.rf_re_n, o.rf_first); end
        n_asserts++; if (o.lat != 2 || o.err !== 2'd0 || o.rdata !== '0) begin n_fail++; $display("FAIL rf_wr_rsp: lat=%0d err=%0d rdata=%h want 2,0,0", o.lat, o.err, o.rdata); end
        run_cmd(1'b0, 1'b1, 32'd5, 32'h0, 1'b1, 0, 0, o);
        n_asserts++; if (o.lat != 3 || o.err !== 2'd0 || o.rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL rf_rd_rsp: lat=%0d err=%0d rdata=%h want 3,0,12345678", o.lat, o.err, o.rdata); end
        n_asserts++; if (o.rf_re_n != 1 || o.rf_we_n != 0 || o.mem_cyc != 0) begin n_fail++; $display("FAIL rf_rd_strobe: re=%0d we=%0d mem=%0d want 1,0,0", o.rf_re_n, o.rf_we_n, o.mem_cyc); end
        // r0 write still strobes; r0 read passes the file's value through.
        run_cmd(1'b1, 1'b1, 32'd0, 32'hFFFF_FFFF, 1'b1, 0, 0, o);
        n_asserts++; if (o.rf_we_n != 1 || o.lat != 2) begin n_fail++; $display("FAIL rf_r0_wr: we=%0d lat=%0d want 1,2", o.rf_we_n, o.lat); end
        run_cmd(1'b0, 1'b1, 32'd0, 32'h0, 1'b1, 0, 0, o);
        n_asserts++; if (o.rdata !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL rf_r0_rd: rdata=%h want 0badf00d", o.rdata); end
    endtask

    task automatic test_errors();
        obs_t o;
        run_cmd(1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 1, 0, o);
        n_asserts++; if (o.err !== 2'd1 || o.lat != 1 || o.rdata !== '0) begin n_fail++; $display("FAIL err_running: err=%0d lat=%0d rdata=%h want 1,1,0", o.err, o.lat, o.rdata); end
        n_asserts++; if (o.mem_cyc + o.rf_re_n + o.rf_we_n != 0) begin n_fail++; $display("FAIL err_running_bus: activity=%0d want 0", o.mem_cyc + o.rf_re_n + o.rf_we_n); end
        run_cmd(1'b0, 1'b0, 32'h102, 32'h0, 1'b1, 1, 0, o);
        n_asserts++; if (o.err !== 2'd2 || o.lat != 1 || o.mem_cyc != 0) begin n_fail++; $display("FAIL err_misalign: err=%0d lat=%0d mem=%0d want 2,1,0", o.err, o.lat, o.mem_cyc); end
        run_cmd(1'b1, 1'b1, 32'd32, 32'h55, 1'b1, 0, 0, o);
        n_asserts++; if (o.err !== 2'd2 || o.lat != 1 || o.rf_re_n + o.rf_we_n != 0) begin n_fail++; $display("FAIL err_regidx: err=%0d lat=%0d rf=%0d want 2,1,0", o.err, o.lat, o.rf_re_n + o.rf_we_n); end
        // Halt check outranks the address check.
        run_cmd(1'b0, 1'b1, 32'd40, 32'h0, 1'b0, 0, 0, o);
        n_asserts++; if (o.err !== 2'd1) begin n_fail++; $display("FAIL err_priority: err=%0d want 1", o.err); end
    endtask

    task automatic test_timeout();
        obs_t o;
        late_ack_en = 1'b1;
        run_cmd(1'b0, 1'b0, 32'h80, 32'h0, 1'b1, 0, 2, o);
        late_ack_en = 1'b0;
        n_asserts++; if (o.mem_cyc != TMO || o.lat != TMO + 1) begin n_fail++; $display("FAIL tmo_timing: mem_req cycles=%0d lat=%0d want %0d,%0d", o.mem_cyc, o.lat, TMO, TMO + 1); end
        n_asserts++; if (o.err !== 2'd3 || o.rdata !== '0 || !o.stable) begin n_fail++; $display("FAIL tmo_rsp: err=%0d rdata=%h stable=%b want 3,0,1", o.err, o.rdata, o.stable); end
        mem_ack = 1'b1;
        repeat (2) begin
            @(posedge CLK); #1;
            n_asserts++; if (rsp_valid !== 1'b0 || mem_req !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL tmo_late_ack: rsp_valid=%b mem_req=%b req_ready=%b want 0,0,1", rsp_valid, mem_req, req_ready); end
        end
        mem_ack = 1'b0;
        run_cmd(1'b1, 1'b0, 32'h40, 32'hCAFE_0001, 1'b1, 2, 0, o);
        n_asserts++; if (o.err !== 2'd0 || o.lat != 3 || o.mem_cyc != 2) begin n_fail++; $display("FAIL tmo_next_cmd: err=%0d lat=%0d mem=%0d want 0,3,2", o.err, o.lat, o.mem_cyc); end
    endtask

    task automatic test_rsp_hold();
        obs_t o;
        run_cmd(1'b0, 1'b1, 32'd5, 32'h0, 1'b1, 0, 10, o);
        n_asserts++; if (!o.stable || o.rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL hold_stable: stable=%b rdata=%h want 1,12345678", o.stable, o.rdata); end
        n_asserts++; if (!o.idle_after) begin n_fail++; $display("FAIL hold_release: not back in idle one edge after rsp_ready"); end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        req_valid = 1'b1; req_write = 1'b0; req_target = 1'b0;
        req_addr  = 32'h200; req_wdata = 32'h0; core_halt = 1'b1;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        n_asserts++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_start: mem_req=%b want 1", mem_req); end
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        n_asserts++; if (mem_req !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0 || rsp_err !== 2'd0) begin n_fail++; $display("FAIL rstmid_edge: mem_req=%b rsp_valid=%b req_ready=%b err=%0d want 0,0,0,0", mem_req, rsp_valid, req_ready, rsp_err); end
        RST = 1'b0;
        #1;
        n_asserts++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: req_ready=%b want 1", req_ready); end
        @(posedge CLK); #1;
        run_cmd(1'b0, 1'b1, 32'd5, 32'h0, 1'b1, 0, 0, o);
        n_asserts++; if (o.lat != 3 || o.err !== 2'd0 || o.rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL rstmid_after: lat=%0d err=%0d rdata=%h want 3,0,12345678", o.lat, o.err, o.rdata); end
    endtask

    task automatic test_random();
        obs_t o, e;
        bit wr, tgt, halt;
        logic [31:0] addr, wd;
        int ack, hold;
        for (int n = 0; n < 60; n++) begin
            wr   = 1'($urandom);
            tgt  = 1'($urandom);
            halt = ($urandom_range(0, 9) != 0);
            wd   = $urandom;
            if (tgt) begin
                addr = $urandom_range(0, 40);
            end else begin
                addr = 32'($urandom_range(0, 63)) * 4;
                if ($urandom_range(0, 3) == 0) addr = addr + 32'($urandom_range(1, 3));
            end
            ack  = $urandom_range(0, 6);
            hold = $urandom_range(0, 3);
            e = predict(wr, tgt, addr, halt, ack);
            run_cmd(wr, tgt, addr, wd, halt, ack, hold, o);
            n_asserts++;
            if (o.lat != e.lat || o.err !== e.err || o.rdata !== e.rdata ||
                o.mem_cyc != e.mem_cyc || o.rf_re_n != e.rf_re_n ||
                o.rf_we_n != e.rf_we_n || o.rf_first != e.rf_first ||
                !o.stable || !o.mem_ok || !o.idle_after) begin
                n_fail++;
                $display("FAIL random[%0d] wr=%b tgt=%b addr=%h halt=%b ack=%0d: got lat=%0d err=%0d rdata=%h mem=%0d re=%0d we=%0d rf1=%0d st=%b bus=%b idle=%b want lat=%0d err=%0d rdata=%h mem=%0d re=%0d we=%0d rf1=%0d st=1 bus=1 idle=1",
                         n, wr, tgt, addr, halt, ack, o.lat, o.err, o.rdata, o.mem_cyc,
                         o.rf_re_n, o.rf_we_n, o.rf_first, o.stable, o.mem_ok, o.idle_after,
                         e.lat, e.err, e.rdata, e.mem_cyc, e.rf_re_n, e.rf_we_n, e.rf_first);
            end
        end
    endtask

    initial begin
        RST = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_target = 1'b0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b0; core_halt = 1'b1;
        mem_ack = 1'b0; mem_rdata = '0; rf_rdata = '0;
        for (int i = 0; i < 32; i++) rf_model[i] = 32'h1000_0000 + 32'(i);
        rf_model[0] = 32'h0BAD_F00D;

        test_reset();
        test_mem();
        test_regs();
        test_errors();
        test_timeout();
        test_rsp_hold();
        test_reset_mid();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/codix_risc_dbg_responder.md
# codix_risc_dbg_responder

Backdoor-access responder for the codix_risc platform. It accepts single read/write commands targeting data memory or the general register file from the verification/debug side over a valid/ready request channel. It executes each command on the memory bus or the register-file debug port and returns one response per command. It is the RTL end of the get/set mem and get/set regs accesses that the golden model exposes, so the same stimulus can drive both the golden model and the RTL platform.

## Interface
Parameters:
- ADDR_W, 32, byte address width of req_addr and mem_addr
- DATA_W, 32, data width
- TIMEOUT, 255, maximum number of MEM_WAIT cycles before abort (1..65535)

Ports:
- CLK  in  1  clock; all logic is rising-edge
- RST  in  1  synchronous, active-high reset
- req_valid  in  1  command present
- req_ready  out  1  responder can accept a command
- req_write  in  1  1 = write, 0 = read
- req_target  in  1  0 = memory, 1 = register file
- req_addr  in  ADDR_W  memory byte address, or register index
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  DATA_W  read data; 0 for writes and for errors
- rsp_err  out  2  0 = OK, 1 = core not halted, 2 = bad address, 3 = memory timeout
- core_halt  in  1  core halt status
- mem_req  out  1  memory request; held until ack or timeout
- mem_we  out  1  memory write enable; valid while mem_req is high
- mem_addr  out  ADDR_W  memory byte address
- mem_wdata  out  DATA_W  memory write data
- mem_ack  in  1  memory completion; sampled only while mem_req is high
- mem_rdata  in  DATA_W  read data; valid with mem_ack
- rf_re  out  1  register read strobe, one cycle
- rf_we  out  1  register write strobe, one cycle
- rf_addr  out  5  register index
- rf_wdata  out  DATA_W  register write data
- rf_rdata  in  DATA_W  register data; valid the cycle after rf_re

## Operation
- States: IDLE, MEM_WAIT, RF_ACC, RF_CAP, RESP.
- IDLE: req_ready=1. A handshake (req_valid & req_ready) latches write, target, addr, wdata and the current core_halt value.
- Checks at acceptance, in priority order:
  - core_halt=0 -> RESP with err=1.
  - Memory target with addr[1:0]!=0 -> RESP with err=2.
  - Register target with req_addr>=32 -> RESP with err=2.
  - Otherwise memory -> MEM_WAIT, register -> RF_ACC.
- MEM_WAIT: mem_req=1 and mem_we/addr/wdata are held stable.
  - mem_ack=1 -> latch mem_rdata (reads only; writes return 0), err=0, go to RESP.
  - A wait counter is cleared on entry and increments each MEM_WAIT cycle without ack. When it reaches TIMEOUT, mem_req drops, err=3, rdata=0, go to RESP.
- RF_ACC: exactly one cycle of rf_re (read) or rf_we (write), with rf_addr=addr[4:0].
  - A write to r0 still issues rf_we; the register file ignores it.
  - Write -> RESP, err=0. Read -> RF_CAP.
- RF_CAP: latch rf_rdata into rsp_rdata, err=0, go to RESP. A read of index 0 returns rf_rdata unchanged; the responder does not force it to 0.
- RESP: rsp_valid=1 with rdata/err held stable until rsp_ready=1, then IDLE.
- A mem_ack outside MEM_WAIT, including a late ack after a timeout, is ignored.
- Only one command is outstanding at a time. No pipelining.

## Timing
- Reset values: req_ready=0 during reset, then 1 in the first cycle after RST deasserts. rsp_valid, mem_req, mem_we, rf_re, rf_we = 0. All address, data, rdata and err outputs = 0. State = IDLE, counter = 0.
- Cycle 0 is the acceptance edge. Latencies to first rsp_valid cycle:
  - Error: cycle 1.
  - Register write: rf_we in cycle 1, rsp_valid in cycle 2.
  - Register read: rf_re in cycle 1, capture in cycle 2, rsp_valid in cycle 3.
  - Memory: mem_req from cycle 1. An ack in cycle k gives rsp_valid in cycle k+1. With no ack, mem_req is high for cycles 1..TIMEOUT and rsp_valid appears in cycle TIMEOUT+1.
- req_ready=0 in every state except IDLE.
- An rsp_ready in the first RESP cycle returns the block to IDLE on the next edge, so back-to-back commands are spaced by at least one IDLE cycle.
- RST mid-operation: all outputs return to reset values on the same edge. Any pending command is dropped without a response, and mem_req drops immediately.
- core_halt changing after acceptance has no effect on the command in flight.

## Test plan
- Halted core, memory write 0xDEADBEEF to 0x100 with ack after 3 cycles, then read 0x100 returning 0xDEADBEEF -> write response err=0 rdata=0; read response rdata=0xDEADBEEF; mem_req high for exactly 3 cycles on each.
- Register write r5=0x12345678, then read r5 with the model returning it -> rf_we one cycle in cycle 1; read rsp_valid in cycle 3 with rdata=0x12345678, err=0.
- core_halt=0 with any command; memory read at 0x102; register index 32 -> err=1, err=2, err=2 respectively, each at cycle 1, with no mem_req/rf_* activity.
- TIMEOUT=4 and memory never acks, then a late ack is driven -> mem_req high cycles 1-4, response err=3 rdata=0 in cycle 5; the late ack does not disturb the next command.
- rsp_ready held low for 10 cycles -> rsp_valid, rdata and err stay stable; req_ready stays 0; return to IDLE one edge after rsp_ready rises.
- RST asserted during MEM_WAIT -> mem_req=0 and rsp_valid=0 on the reset edge; after release a fresh register read completes normally.
